// File: rtl/pp_mem_loader.sv
// Byte-stream program loader: receives a framed image (count, big-endian words,
// checksum), writes it into program memory, then reads it back to verify.
module pp_mem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              ok,
    output logic [1:0]        err_code
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CAP   = 1 << ADDR_W;

    typedef enum logic [3:0] {
        IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, CHK_HI, CHK_LO, VERIFY, DONE
    } state_t;

    state_t state, state_d;

    logic [CNT_W-1:0]  n_q, n_d, idx_q, idx_d, ridx_q, ridx_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       rsum_q, rsum_d, wsum_q, wsum_d, vsum_q, vsum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              w_en_q, w_en_d, in_ready_q, in_ready_d;
    logic              busy_q, busy_d, done_q, done_d, ok_q, ok_d;
    logic [1:0]        err_q, err_d;

    logic              accept;
    logic [15:0]       rx_word;
    logic [CNT_W-1:0]  idx_inc, ridx_inc;

    assign accept   = in_valid & in_ready_q;
    assign rx_word  = {hi_q, in_data};
    assign idx_inc  = idx_q + CNT_W'(1);
    assign ridx_inc = ridx_q + CNT_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            ridx_q     <= '0;
            hi_q       <= '0;
            rsum_q     <= '0;
            wsum_q     <= '0;
            vsum_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            w_en_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= '0;
        end else begin
            state      <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            ridx_q     <= ridx_d;
            hi_q       <= hi_d;
            rsum_q     <= rsum_d;
            wsum_q     <= wsum_d;
            vsum_q     <= vsum_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            w_en_q     <= w_en_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    // Next-state and next-output logic; outputs are registered from state_d
    always_comb begin
        state_d = state;
        n_d     = n_q;
        idx_d   = idx_q;
        ridx_d  = ridx_q;
        hi_d    = hi_q;
        rsum_d  = rsum_q;
        wsum_d  = wsum_q;
        vsum_d  = vsum_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ok_d    = ok_q;
        err_d   = err_q;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = HDR_HI;
                    ok_d    = 1'b0;
                    err_d   = 2'd0;
                    n_d     = '0;
                    idx_d   = '0;
                    ridx_d  = '0;
                    rsum_d  = '0;
                    wsum_d  = '0;
                    vsum_d  = '0;
                end
            end
            HDR_HI, DAT_HI, CHK_HI: begin
                if (accept) begin
                    hi_d = in_data;
                    state_d = (state == HDR_HI) ? HDR_LO :
                              (state == DAT_HI) ? DAT_LO : CHK_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    if (rx_word == 16'd0 || 32'(rx_word) > CAP) begin
                        state_d = DONE;
                        err_d   = 2'd1;
                        ok_d    = 1'b0;
                    end else begin
                        n_d     = CNT_W'(rx_word);
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_LO: begin
                if (accept) begin
                    wdata_d = rx_word;
                    addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wsum_d  = wsum_q + wdata_q;
                idx_d   = idx_inc;
                state_d = (idx_inc < n_q) ? DAT_HI : CHK_HI;
            end
            CHK_LO: begin
                if (accept) begin
                    rsum_d  = rx_word;
                    ridx_d  = '0;
                    addr_d  = ADDR_W'(BASE_ADDR);
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                vsum_d = vsum_q + mem_rdata;
                ridx_d = ridx_inc;
                if (ridx_inc < n_q) begin
                    addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(ridx_inc);
                end else begin
                    state_d = DONE;
                    // Stream checksum error outranks readback error
                    if (rsum_q != wsum_q) begin
                        err_d = 2'd2;
                    end else if (vsum_d != wsum_q) begin
                        err_d = 2'd3;
                    end else begin
                        err_d = 2'd0;
                    end
                    ok_d = (rsum_q == wsum_q) && (vsum_d == wsum_q);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        w_en_d     = (state_d == WRITE);
        in_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                     (state_d == DAT_HI) || (state_d == DAT_LO) ||
                     (state_d == CHK_HI) || (state_d == CHK_LO);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign mem_w_en  = w_en_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ok        = ok_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_pp_mem_loader.sv
// Directed bench for pp_mem_loader: two instances (base 0 and base 0x3FE) share
// one byte stream, each with its own behavioural 1024x16 memory.
module tb_pp_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        corrupt = 1'b0;

    logic        rdy0, wen0, busy0, done0, ok0;
    logic        rdy1, wen1, busy1, done1, ok1;
    logic [9:0]  addr0, addr1;
    logic [15:0] wd0, wd1, rd0, rd1;
    logic [1:0]  err0, err1;

    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_total0 = 0, wr_total1 = 0, dbl_wen = 0;
    logic [9:0] wr_addr0 [64];
    logic [9:0] wr_addr1 [64];
    int         wr_cyc0 [64];
    logic       wen0_d = 1'b0;

    always #5 clk = ~clk;

    pp_mem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .mem_w_en(wen0), .mem_addr(addr0), .mem_wdata(wd0), .mem_rdata(rd0),
        .busy(busy0), .done(done0), .ok(ok0), .err_code(err0));

    pp_mem_loader #(.ADDR_W(10), .BASE_ADDR(10'h3FE)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .mem_w_en(wen1), .mem_addr(addr1), .mem_wdata(wd1), .mem_rdata(rd1),
        .busy(busy1), .done(done1), .ok(ok1), .err_code(err1));

    // Memory models; corrupt forces a bad readback of the second image word
    assign rd0 = (corrupt && addr0 == 10'h001) ? 16'hABCC : mem0[addr0];
    assign rd1 = (corrupt && addr1 == 10'h3FF) ? 16'hABCC : mem1[addr1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        wen0_d <= wen0;
        if (wen0 && wen0_d) dbl_wen <= dbl_wen + 1;
        if (wen0) begin
            mem0[addr0] <= wd0;
            wr_addr0[wr_total0[5:0]] <= addr0;
            wr_cyc0[wr_total0[5:0]]  <= cyc;
            wr_total0 <= wr_total0 + 1;
        end
        if (wen1) begin
            mem1[addr1] <= wd1;
            wr_addr1[wr_total1[5:0]] <= addr1;
            wr_total1 <= wr_total1 + 1;
        end
    end

    typedef struct {
        logic [15:0] hdr;
        logic [15:0] w0, w1, w2;
        logic [15:0] chk;
        bit          bad_rd;
        bit          gaps;
        logic [1:0]  exp_err;
        bit          exp_ok;
        int          exp_wr;
    } vec_t;

    vec_t vecs [7];
    logic [9:0] last_addr0 = 10'h000;
    logic [9:0] last_addr1 = 10'h000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " w_en0"}, 32'(wen0), 32'd0);
        check({tag, " addr0"}, 32'(addr0), 32'd0);
        check({tag, " wdata0"}, 32'(wd0), 32'd0);
        check({tag, " ready0"}, 32'(rdy0), 32'd0);
        check({tag, " flags0"}, {28'd0, busy0, done0, ok0, 1'b0}, 32'd0);
        check({tag, " err0"}, 32'(err0), 32'd0);
        check({tag, " outs1"}, {wen1, rdy1, busy1, done1, ok1, err1, addr1, wd1}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte (after optional idle gap) and return just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        if (gap > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!rdy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) check("accept timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    function automatic logic [15:0] word_of(input vec_t v, input int i);
        return (i == 0) ? v.w0 : (i == 1) ? v.w1 : v.w2;
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        int b0 = wr_total0, b1 = wr_total1;
        int n, g, waited;
        logic [15:0] w;
        corrupt = v.bad_rd;
        pulse_start();
        check($sformatf("v%0d busy after start", k), 32'({busy0, busy1}), 32'd3);
        send_byte(v.hdr[15:8], 0);
        send_byte(v.hdr[7:0], 0);
        if (v.exp_err != 2'd1) begin
            n = int'(v.hdr);
            for (int i = 0; i < n; i++) begin
                w = word_of(v, i);
                g = v.gaps ? int'($urandom_range(0, 3)) : 0;
                send_byte(w[15:8], g);
                if (v.gaps && i == 1) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                g = v.gaps ? int'($urandom_range(0, 3)) : 0;
                send_byte(w[7:0], g);
            end
            send_byte(v.chk[15:8], v.gaps ? 2 : 0);
            send_byte(v.chk[7:0], 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!done0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("v%0d done", k), 32'({done0, done1}), 32'd3);
        check($sformatf("v%0d err0", k), 32'(err0), 32'(v.exp_err));
        check($sformatf("v%0d err1", k), 32'(err1), 32'(v.exp_err));
        check($sformatf("v%0d ok", k), 32'({ok0, ok1}), v.exp_ok ? 32'd3 : 32'd0);
        check($sformatf("v%0d busy in done", k), 32'(busy0), 32'd1);
        check($sformatf("v%0d writes0", k), 32'(wr_total0 - b0), 32'(v.exp_wr));
        check($sformatf("v%0d writes1", k), 32'(wr_total1 - b1), 32'(v.exp_wr));
        if (v.exp_wr > 0) begin
            last_addr0 = 10'(v.exp_wr - 1);
            last_addr1 = 10'(10'h3FE + v.exp_wr - 1);
        end
        for (int i = 0; i < v.exp_wr; i++) begin
            check($sformatf("v%0d waddr0[%0d]", k, i), 32'(wr_addr0[6'(b0 + i)]), 32'(i));
            check($sformatf("v%0d waddr1[%0d]", k, i), 32'(wr_addr1[6'(b1 + i)]),
                  32'(10'(10'h3FE + i)));
            check($sformatf("v%0d mem0[%0d]", k, i), 32'(mem0[i]), 32'(word_of(v, i)));
            check($sformatf("v%0d mem1[%0d]", k, i), 32'(mem1[10'(10'h3FE + i)]),
                  32'(word_of(v, i)));
            if (!v.gaps && i > 0)
                check($sformatf("v%0d spacing[%0d]", k, i),
                      32'(wr_cyc0[6'(b0 + i)] - wr_cyc0[6'(b0 + i - 1)]), 32'd3);
        end
        @(negedge clk);
        check($sformatf("v%0d done pulse", k), 32'({done0, busy0}), 32'd0);
        check($sformatf("v%0d ok held", k), 32'(ok0), 32'(v.exp_ok));
        check($sformatf("v%0d addr0 held", k), 32'(addr0), 32'(last_addr0));
        check($sformatf("v%0d addr1 held", k), 32'(addr1), 32'(last_addr1));
        corrupt = 1'b0;
    endtask

    initial begin
        //          hdr       w0        w1        w2        chk       bad gap err  ok wr
        vecs[0] = '{16'h0003, 16'h1234, 16'hABCD, 16'h0001, 16'hBE02, 0, 0, 2'd0, 1, 3};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd1, 0, 0};
        vecs[2] = '{16'h0401, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2'd1, 0, 0};
        vecs[3] = '{16'h0003, 16'h1234, 16'hABCD, 16'h0001, 16'hBE03, 0, 0, 2'd2, 0, 3};
        vecs[4] = '{16'h0003, 16'h1234, 16'hABCD, 16'h0001, 16'hBE02, 1, 0, 2'd3, 0, 3};
        vecs[5] = '{16'h0003, 16'h5555, 16'hAAAA, 16'h0102, 16'h0101, 0, 1, 2'd0, 1, 3};
        vecs[6] = '{16'h0001, 16'h00FF, 16'h0000, 16'h0000, 16'h00FF, 0, 0, 2'd0, 1, 1};

        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 16'h0000;
            mem1[i] = 16'h0000;
        end

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

        // Reset during the second WRITE of an N=3 load
        begin
            int b0;
            b0 = wr_total0;
            pulse_start();
            send_byte(8'h00, 0);
            send_byte(8'h03, 0);
            send_byte(8'h12, 0);
            send_byte(8'h34, 0);
            send_byte(8'hAB, 0);
            send_byte(8'hCD, 0);
            @(negedge clk);
            in_valid = 1'b0;
            check("mid-load second write", {31'd0, wen0}, 32'd1);
            check("mid-load write addr", 32'(addr0), 32'd1);
            #1 rst_n = 1'b0;
            #1 check_idle_outputs("async reset");
            @(negedge clk);
            check("aborted write count", 32'(wr_total0 - b0), 32'd1);
            rst_n = 1'b1;
            last_addr0 = 10'h000;
            last_addr1 = 10'h000;
            @(negedge clk);
            run_vec(7, vecs[0]);
        end

        check("back-to-back w_en", 32'(dbl_wen), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
